// File: rtl/trax_turn_controller.sv
// Turn sequencer for the TRAX player: colour latch, turn alternation,
// board updates and move hand-off. Optional engine timeout: TRAX_TIMEOUT_EN.
module trax_turn_controller #(
  parameter int MOVE_W         = 22,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              end_receive,
  input  logic [MOVE_W-1:0] move_out,
  input  logic              color,
  input  logic              tx_done,
  output logic [MOVE_W-1:0] move_in,
  output logic              start_transmit,
  output logic              board_wr,
  output logic [MOVE_W-1:0] board_move,
  input  logic              board_ack,
  input  logic              game_over,
  output logic              engine_req,
  input  logic [MOVE_W-1:0] engine_move,
  input  logic              engine_valid,
  output logic              my_color,
  output logic [7:0]        turn_count,
  output logic              err_protocol,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    S_COLOR,
    S_WAIT_OPP,
    S_APPLY_OPP,
    S_THINK,
    S_APPLY_OWN,
    S_SEND,
    S_HALT
  } state_t;

  state_t            state_q;
  logic [MOVE_W-1:0] move_in_q;
  logic              start_tx_q;
  logic              board_wr_q;
  logic [MOVE_W-1:0] board_move_q;
  logic              engine_req_q;
  logic              my_color_q;
  logic [7:0]        turn_q;
  logic              err_prot_q;

`ifdef TRAX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]  cnt_q;
  logic              err_to_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TIMEOUT_CYCLES), 32'(CNT_W)};
`endif

  // Turn FSM; every output is a register updated here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_COLOR;
      move_in_q    <= '0;
      start_tx_q   <= 1'b0;
      board_wr_q   <= 1'b0;
      board_move_q <= '0;
      engine_req_q <= 1'b0;
      my_color_q   <= 1'b0;
      turn_q       <= '0;
      err_prot_q   <= 1'b0;
`ifdef TRAX_TIMEOUT_EN
      cnt_q        <= '0;
      err_to_q     <= 1'b0;
`endif
    end else begin
      start_tx_q <= 1'b0;
`ifdef TRAX_TIMEOUT_EN
      // Held at zero outside S_THINK, so it is zero on entry.
      if (state_q != S_THINK) cnt_q <= '0;
`endif
      case (state_q)
        S_COLOR: begin
          if (end_receive) begin
            my_color_q <= color;
            if (color) begin
              state_q      <= S_THINK;
              engine_req_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_OPP;
            end
          end
        end
        S_WAIT_OPP: begin
          if (end_receive) begin
            board_move_q <= move_out;
            board_wr_q   <= 1'b1;
            state_q      <= S_APPLY_OPP;
          end
        end
        S_APPLY_OPP: begin
          if (end_receive) err_prot_q <= 1'b1;
          if (board_ack) begin
            board_wr_q <= 1'b0;
            turn_q     <= turn_q + 8'd1;
            if (game_over) begin
              state_q <= S_HALT;
            end else begin
              state_q      <= S_THINK;
              engine_req_q <= 1'b1;
            end
          end
        end
        S_THINK: begin
          if (end_receive) err_prot_q <= 1'b1;
          if (engine_valid) begin
            move_in_q    <= engine_move;
            board_move_q <= engine_move;
            engine_req_q <= 1'b0;
            board_wr_q   <= 1'b1;
            state_q      <= S_APPLY_OWN;
          end
`ifdef TRAX_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            engine_req_q <= 1'b0;
            err_to_q     <= 1'b1;
            state_q      <= S_HALT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_APPLY_OWN: begin
          if (end_receive) err_prot_q <= 1'b1;
          if (board_ack) begin
            board_wr_q <= 1'b0;
            start_tx_q <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          if (end_receive) err_prot_q <= 1'b1;
          if (tx_done) begin
            turn_q  <= turn_q + 8'd1;
            state_q <= game_over ? S_HALT : S_WAIT_OPP;
          end
        end
        S_HALT: begin
          if (end_receive) err_prot_q <= 1'b1;
        end
        default: state_q <= S_COLOR;
      endcase
    end
  end

  assign move_in        = move_in_q;
  assign start_transmit = start_tx_q;
  assign board_wr       = board_wr_q;
  assign board_move     = board_move_q;
  assign engine_req     = engine_req_q;
  assign my_color       = my_color_q;
  assign turn_count     = turn_q;
  assign err_protocol   = err_prot_q;
`ifdef TRAX_TIMEOUT_EN
  assign err_timeout    = err_to_q;
`else
  assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_trax_turn_controller.sv
// Scoreboard bench for trax_turn_controller: directed strobes queue
// expected output snapshots; a negedge monitor pops and compares them.
module tb_trax_turn_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        end_receive = 1'b0;
  logic [21:0] move_out = '0;
  logic        color = 1'b0;
  logic        tx_done = 1'b0;
  logic [21:0] move_in;
  logic        start_transmit;
  logic        board_wr;
  logic [21:0] board_move;
  logic        board_ack = 1'b0;
  logic        game_over = 1'b0;
  logic        engine_req;
  logic [21:0] engine_move = '0;
  logic        engine_valid = 1'b0;
  logic        my_color;
  logic [7:0]  turn_count;
  logic        err_protocol;
  logic        err_timeout;

  trax_turn_controller #(
    .MOVE_W(22),
    .TIMEOUT_CYCLES(16),
    .CNT_W(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .end_receive(end_receive),
    .move_out(move_out),
    .color(color),
    .tx_done(tx_done),
    .move_in(move_in),
    .start_transmit(start_transmit),
    .board_wr(board_wr),
    .board_move(board_move),
    .board_ack(board_ack),
    .game_over(game_over),
    .engine_req(engine_req),
    .engine_move(engine_move),
    .engine_valid(engine_valid),
    .my_color(my_color),
    .turn_count(turn_count),
    .err_protocol(err_protocol),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [21:0] mi;
    logic        st;
    logic        bw;
    logic [21:0] bm;
    logic        er;
    logic        mc;
    logic [7:0]  tc;
    logic        ep;
    logic        et;
  } outs_t;

  typedef struct {
    string name;
    int    at;
    outs_t val;
  } item_t;

  outs_t       act;
  outs_t       exp_o;
  item_t       sq[$];
  logic [21:0] txq[$];
  int          ncyc = 0;
  int          total = 0;
  int          bad = 0;

  assign act = {move_in, start_transmit, board_wr, board_move,
                engine_req, my_color, turn_count, err_protocol,
                err_timeout};

  task automatic chk(input string nm, input outs_t a, input outs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got mi=%h st=%b bw=%b bm=%h er=%b mc=%b tc=%0d ep=%b et=%b want mi=%h st=%b bw=%b bm=%h er=%b mc=%b tc=%0d ep=%b et=%b",
        nm, a.mi, a.st, a.bw, a.bm, a.er, a.mc, a.tc, a.ep, a.et,
        e.mi, e.st, e.bw, e.bm, e.er, e.mc, e.tc, e.ep, e.et);
    end
  endtask

  // Monitor: snapshots due this cycle plus every start_transmit pulse.
  initial begin
    forever begin
      @(negedge clock);
      ncyc++;
      while (sq.size() > 0 && sq[0].at <= ncyc) begin
        item_t it;
        it = sq.pop_front();
        chk(it.name, act, it.val);
      end
      if (start_transmit === 1'b1) begin
        total++;
        if (txq.size() == 0) begin
          bad++;
          $display("FAIL tx_pulse: got unexpected start_transmit move=%h",
                   move_in);
        end else begin
          logic [21:0] m;
          m = txq.pop_front();
          if (move_in !== m) begin
            bad++;
            $display("FAIL tx_move: got %h want %h", move_in, m);
          end
        end
      end
    end
  end

  task automatic expect_next(input string nm);
    item_t it;
    it.name = nm;
    it.at   = ncyc + 1;
    it.val  = exp_o;
    sq.push_back(it);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
    end_receive  = 1'b0;
    tx_done      = 1'b0;
    board_ack    = 1'b0;
    engine_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_o = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_o = '0;
    tick();
    tick();
    reset = 1'b0;
    expect_next("reset_state");
    tick();

    // White: engine asked next cycle, nothing written to the board.
    end_receive = 1'b1; color = 1'b1;
    exp_o.mc = 1'b1; exp_o.er = 1'b1;
    expect_next("white_color");
    tick();
    expect_next("white_hold");
    tick();

    // Frame during S_THINK is dropped and flagged.
    end_receive = 1'b1; move_out = 22'h111111;
    exp_o.ep = 1'b1;
    expect_next("perr_think");
    tick();

    engine_valid = 1'b1; engine_move = 22'h2AAAAA;
    exp_o.er = 1'b0; exp_o.bw = 1'b1;
    exp_o.bm = 22'h2AAAAA; exp_o.mi = 22'h2AAAAA;
    expect_next("white_own_wr");
    tick();

    board_ack = 1'b1;
    exp_o.bw = 1'b0; exp_o.st = 1'b1;
    txq.push_back(22'h2AAAAA);
    expect_next("white_own_ack");
    tick();
    exp_o.st = 1'b0;
    expect_next("st_one_cycle");
    tick();

    tx_done = 1'b1;
    exp_o.tc = 8'd1;
    expect_next("white_sent");
    tick();

    // Stray ack in S_WAIT_OPP is ignored.
    board_ack = 1'b1;
    expect_next("stray_ack");
    tick();

    end_receive = 1'b1; move_out = 22'h0ABCDE;
    exp_o.bw = 1'b1; exp_o.bm = 22'h0ABCDE;
    expect_next("opp_wr");
    tick();
    board_ack = 1'b1;
    exp_o.bw = 1'b0; exp_o.tc = 8'd2; exp_o.er = 1'b1;
    expect_next("opp_ack");
    tick();
    engine_valid = 1'b1; engine_move = 22'h012345;
    exp_o.er = 1'b0; exp_o.bw = 1'b1;
    exp_o.bm = 22'h012345; exp_o.mi = 22'h012345;
    expect_next("own_wr2");
    tick();

    // Asynchronous reset in S_APPLY_OWN.
    reset = 1'b1;
    #1;
    chk("reset_async", act, '0);
    exp_o = '0;
    expect_next("reset_hold");
    tick();
    reset = 1'b0;
    tick();

    // Black full turn.
    end_receive = 1'b1; color = 1'b0;
    expect_next("black_color");
    tick();
    end_receive = 1'b1; move_out = 22'h0ABCDE;
    exp_o.bw = 1'b1; exp_o.bm = 22'h0ABCDE;
    expect_next("black_opp_wr");
    tick();
    expect_next("black_wr_hold");
    tick();
    board_ack = 1'b1;
    exp_o.bw = 1'b0; exp_o.tc = 8'd1; exp_o.er = 1'b1;
    expect_next("black_opp_ack");
    tick();
    engine_valid = 1'b1; engine_move = 22'h012345;
    exp_o.er = 1'b0; exp_o.bw = 1'b1;
    exp_o.bm = 22'h012345; exp_o.mi = 22'h012345;
    expect_next("black_own_wr");
    tick();
    board_ack = 1'b1;
    exp_o.bw = 1'b0; exp_o.st = 1'b1;
    txq.push_back(22'h012345);
    expect_next("black_own_ack");
    tick();
    exp_o.st = 1'b0;
    expect_next("black_st_low");
    tick();

    // tx_done wins over a simultaneous frame, which is flagged.
    tx_done = 1'b1; end_receive = 1'b1; move_out = 22'h222222;
    exp_o.tc = 8'd2; exp_o.ep = 1'b1;
    expect_next("tx_and_rx");
    tick();

    end_receive = 1'b1; move_out = 22'h3FFFFF;
    exp_o.bw = 1'b1; exp_o.bm = 22'h3FFFFF;
    expect_next("opp3_wr");
    tick();
    board_ack = 1'b1;
    exp_o.bw = 1'b0; exp_o.tc = 8'd3; exp_o.er = 1'b1;
    expect_next("opp3_ack");
    tick();
    engine_valid = 1'b1; engine_move = 22'h155555;
    exp_o.er = 1'b0; exp_o.bw = 1'b1;
    exp_o.bm = 22'h155555; exp_o.mi = 22'h155555;
    expect_next("own3_wr");
    tick();
    board_ack = 1'b1;
    exp_o.bw = 1'b0; exp_o.st = 1'b1;
    txq.push_back(22'h155555);
    expect_next("own3_ack");
    tick();

    // Game over at turn completion: halt.
    game_over = 1'b1;
    exp_o.st = 1'b0;
    expect_next("own3_st_low");
    tick();
    tx_done = 1'b1;
    exp_o.tc = 8'd4;
    expect_next("halt_enter");
    tick();
    game_over = 1'b0;
    end_receive = 1'b1; move_out = 22'h0000AA;
    expect_next("halt_rx");
    tick();
    engine_valid = 1'b1; board_ack = 1'b1; tx_done = 1'b1;
    expect_next("halt_strobes");
    tick();

`ifdef TRAX_TIMEOUT_EN
    // No engine result within the budget.
    do_reset();
    end_receive = 1'b1; color = 1'b1;
    exp_o.mc = 1'b1; exp_o.er = 1'b1;
    expect_next("to_white");
    tick();
    for (int i = 0; i < 15; i++) begin
      expect_next("to_wait");
      tick();
    end
    exp_o.er = 1'b0; exp_o.et = 1'b1;
    expect_next("to_expire");
    tick();
    expect_next("to_halted");
    tick();

    // Result in the final budget cycle still counts.
    do_reset();
    end_receive = 1'b1; color = 1'b1;
    exp_o.mc = 1'b1; exp_o.er = 1'b1;
    expect_next("to2_white");
    tick();
    for (int i = 0; i < 15; i++) begin
      expect_next("to2_wait");
      tick();
    end
    engine_valid = 1'b1; engine_move = 22'h0F0F0F;
    exp_o.er = 1'b0; exp_o.bw = 1'b1;
    exp_o.bm = 22'h0F0F0F; exp_o.mi = 22'h0F0F0F;
    expect_next("to2_last_valid");
    tick();
    board_ack = 1'b1;
    exp_o.bw = 1'b0; exp_o.st = 1'b1;
    txq.push_back(22'h0F0F0F);
    expect_next("to2_ack");
    tick();
`else
    // Without the timeout S_THINK waits indefinitely.
    do_reset();
    end_receive = 1'b1; color = 1'b1;
    exp_o.mc = 1'b1; exp_o.er = 1'b1;
    expect_next("nto_white");
    tick();
    for (int i = 0; i < 40; i++) tick();
    expect_next("nto_still_think");
    tick();
`endif

    tick();
    tick();
    total++;
    if (sq.size() != 0 || txq.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending=%0d/%0d want 0/0",
               sq.size(), txq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trax_turn_controller.md
# trax_turn_controller

Turn sequencer for the TRAX player. Sits between the `tranceiver` (serial move link), the board memory/update logic and the move engine. Latches our colour from the first received frame, alternates turns, applies every move (opponent's and our own) to the board and hands our move to the transmitter, with optional engine timeout.

## Interface

Parameters:
- `MOVE_W`, 22: move word width; matches `move_in`/`move_out` of `tranceiver`.
- `TIMEOUT_CYCLES`, 50_000_000: engine budget per turn in `clock` cycles; used only with `TRAX_TIMEOUT_EN`.
- `CNT_W`, 26: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: asynchronous, active-high; clears every register below.
- `end_receive` in 1: one-cycle strobe from `tranceiver`, frame received.
- `move_out` in MOVE_W: received move; valid in the `end_receive` cycle.
- `color` in 1: received colour bit; valid in the `end_receive` cycle. 1 = white (moves first).
- `tx_done` in 1: one-cycle strobe from `tranceiver`, transmission finished.
- `move_in` out MOVE_W: registered move for `tranceiver`; reset 0.
- `start_transmit` out 1: one-cycle pulse; reset 0.
- `board_wr` out 1: level request to apply `board_move`; reset 0.
- `board_move` out MOVE_W: move to apply; reset 0.
- `board_ack` in 1: one-cycle strobe, board update complete.
- `game_over` in 1: level from board checker.
- `engine_req` out 1: level, engine must compute our move; reset 0.
- `engine_move` in MOVE_W, `engine_valid` in 1: engine result, valid in the strobe cycle.
- `my_color` out 1: latched colour; reset 0.
- `turn_count` out 8: completed plies, wraps 255→0; reset 0.
- `err_protocol` out 1: sticky; reset 0.
- `err_timeout` out 1: sticky; reset 0; tied 0 without `TRAX_TIMEOUT_EN`.

## Operation

States: S_COLOR, S_WAIT_OPP, S_APPLY_OPP, S_THINK, S_APPLY_OWN, S_SEND, S_HALT. Reset state S_COLOR.
- S_COLOR: on `end_receive`, latch `my_color <= color`. If white → S_THINK, else → S_WAIT_OPP. The colour frame is not a move and is not applied.
- S_WAIT_OPP: on `end_receive`, `board_move <= move_out`, `board_wr <= 1` → S_APPLY_OPP.
- S_APPLY_OPP: hold `board_wr`; on `board_ack`: `board_wr <= 0`, `turn_count++` → S_THINK (or S_HALT if `game_over` is high in that cycle).
- S_THINK: `engine_req` = 1. On `engine_valid`: `move_in <= engine_move`, `board_move <= engine_move`, `engine_req <= 0`, `board_wr <= 1` → S_APPLY_OWN.
- S_APPLY_OWN: on `board_ack`: `board_wr <= 0`, `start_transmit <= 1` (one cycle) → S_SEND.
- S_SEND: on `tx_done`: `turn_count++` → S_HALT if `game_over`, else S_WAIT_OPP.
- S_HALT: all request outputs 0; stays until `reset`.
- `end_receive` in any state other than S_COLOR/S_WAIT_OPP: frame dropped, `err_protocol <= 1`, state unchanged.
- `board_ack`, `tx_done` or `engine_valid` outside their waiting state: ignored, no error.
- `game_over` is evaluated only at the two turn-completion points above; never aborts a transmission in flight.

## Timing

- All outputs registered. `board_wr` rises the cycle after the `end_receive` edge (1-cycle latency); `engine_req` rises the cycle after the `board_ack` edge.
- `start_transmit` high exactly the one cycle after the `board_ack` edge in S_APPLY_OWN; `move_in` stable from S_APPLY_OWN entry until the next S_THINK exit.
- `turn_count` increments on the completing strobe edge, visible next cycle.
- Simultaneous `end_receive` and `tx_done` in S_SEND: `tx_done` honoured, `err_protocol` set.
- `reset` asserted mid-turn: outputs clear asynchronously, no partial `start_transmit`.

## Configuration

- `TRAX_TIMEOUT_EN` defined: counter clears on S_THINK entry, increments each S_THINK cycle; on reaching `TIMEOUT_CYCLES - 1` without `engine_valid`, `engine_req <= 0`, `err_timeout <= 1` → S_HALT. `engine_valid` in the final cycle wins.
- Not defined: no counter; S_THINK waits indefinitely; `err_timeout` constant 0.

## Test plan

- Colour white: `end_receive`, `color`=1 → `my_color`=1, `engine_req`=1 next cycle; no `board_wr`.
- Black full turn: colour 0, then `end_receive` with `move_out`=22'h0ABCDE → `board_wr`=1, `board_move`=22'h0ABCDE; `board_ack` → `turn_count`=1, `engine_req`=1; `engine_move`=22'h012345 → `board_wr`, ack → one-cycle `start_transmit`, `move_in`=22'h012345; `tx_done` → `turn_count`=2, back to S_WAIT_OPP.
- Protocol error: `end_receive` during S_THINK → `err_protocol`=1, `engine_req` stays 1, `board_wr` stays 0.
- Game over: `game_over`=1 at `tx_done` → S_HALT, all requests 0, further `end_receive` ignored.
- Timeout (`TRAX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): no `engine_valid` for 16 cycles → `err_timeout`=1, `engine_req`=0, no `start_transmit`; valid on cycle 16 → normal send.
- Reset mid S_APPLY_OWN → all outputs 0 immediately, state S_COLOR, `turn_count`=0.
